module_debouncer_n: RTL

MODULE_DEBOUNCER_N -- requirements
Module: module_debouncer_n

---
 rtl/module_debouncer_n.sv | 94 +++++++++
 1 files changed

// File: rtl/module_debouncer_n.sv
// Multi-channel push-button debouncer with press/release edge pulses and
// auto-repeat. Every channel is independent; all outputs are registered.
module module_debouncer_n #(
   parameter int N_CH       = 4,
   parameter int STABLE_CYC = 26,
   parameter int REPEAT_DLY = 5000,
   parameter int REPEAT_PER = 1000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] btn,
   input  logic            rep_en,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] press,
   output logic [N_CH-1:0] rel,
   output logic [N_CH-1:0] rpt,
   output logic [N_CH-1:0] tecla,
   output logic            any_evt
);

   localparam int SW   = $clog2(STABLE_CYC) + 1;
   localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int RW   = $clog2(RMAX) + 1;

   localparam logic [SW-1:0] S_LAST = SW'(STABLE_CYC - 1);
   localparam logic [RW-1:0] D_LAST = RW'(REPEAT_DLY - 1);
   localparam logic [RW-1:0] P_LAST = RW'(REPEAT_PER - 1);

   logic [N_CH-1:0] s1, s2;
   logic [SW-1:0]   scnt [N_CH];
   logic [RW-1:0]   rcnt [N_CH];
   logic [N_CH-1:0] first;

   logic [N_CH-1:0] rise, fall, hit, rfire;

   // first marks that the next repeat is the initial one (REPEAT_DLY),
   // afterwards pulses come every REPEAT_PER cycles.
   always_comb begin
      rise  = '0;
      fall  = '0;
      hit   = '0;
      rfire = '0;
      for (int i = 0; i < N_CH; i++) begin
         rise[i]  = s2[i] & ~level[i] & (scnt[i] == S_LAST);
         fall[i]  = ~s2[i] & level[i] & (scnt[i] == S_LAST);
         hit[i]   = level[i] & rep_en & (rcnt[i] == (first[i] ? D_LAST : P_LAST));
         rfire[i] = hit[i] & ~fall[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1      <= '0;
         s2      <= '0;
         level   <= '0;
         press   <= '0;
         rel     <= '0;
         rpt     <= '0;
         tecla   <= '0;
         any_evt <= 1'b0;
         first   <= '1;
         for (int i = 0; i < N_CH; i++) begin
            scnt[i] <= '0;
            rcnt[i] <= '0;
         end
      end else begin
         s1      <= btn;
         s2      <= s1;
         level   <= level ^ (rise | fall);
         press   <= rise;
         rel     <= fall;
         rpt     <= rfire;
         tecla   <= rise | rfire;
         any_evt <= |(rise | rfire);
         for (int i = 0; i < N_CH; i++) begin
            if (s2[i] == level[i] || scnt[i] == S_LAST)
               scnt[i] <= '0;
            else
               scnt[i] <= scnt[i] + 1'b1;

            if (!level[i] || !rep_en) begin
               rcnt[i]  <= '0;
               first[i] <= 1'b1;
            end else if (hit[i]) begin
               rcnt[i]  <= '0;
               first[i] <= 1'b0;
            end else begin
               rcnt[i]  <= rcnt[i] + 1'b1;
            end
         end
      end
   end

endmodule
